host_bus_master: RTL

//  Bus initiator for the baseband host interface. It drives host_cs, host_rd,

---
 rtl/host_bus_master_if.sv | 52 +++++
 rtl/host_bus_master.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/host_bus_master_if.sv
// Command, write-data, read-response and host bus signals of the host bus master.
// master = the initiator's view; slave = the command source / host target view.
interface host_bus_master_if;
  localparam int unsigned AW = 14;
  localparam int unsigned LW = 8;
  localparam int unsigned DW = 32;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic          cmd_incr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;

  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;

  logic          host_cs;
  logic          host_rd;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_d4wt;
  logic [DW-1:0] host_d4rd;

  modport master (
    input  cmd_valid, cmd_write, cmd_incr, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rsp_valid, rsp_data, rsp_last,
    input  rsp_ready,
    output host_cs, host_rd, host_wr, host_addr, host_d4wt,
    input  host_d4rd
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_incr, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rsp_valid, rsp_data, rsp_last,
    output rsp_ready,
    input  host_cs, host_rd, host_wr, host_addr, host_d4wt,
    output host_d4rd
  );
endinterface

// File: rtl/host_bus_master.sv
// Host bus initiator: single/burst reads and writes on the 14-bit DWORD host bus,
// with streamed write data and a credit-controlled read response FIFO.
module host_bus_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RSP_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  host_bus_master_if.master bus,
  output logic              busy
);

  localparam int unsigned AW = 14;
  localparam int unsigned LW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [LW-1:0] remain_q, remain_d;
  logic          incr_q, incr_d;

  logic          cs_q, cs_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          rd_last_q, rd_last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic          busy_q, busy_d;

  logic [READ_LATENCY-1:0] tag_vld_q, tag_last_q;
  logic [READ_LATENCY:0]   vld_chain, last_chain;

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [DW:0]   mem_q [RSP_DEPTH];

  logic issue, push, pop, credit_ok;

  // Tags ride alongside each read strobe and surface when host_d4rd is valid.
  assign vld_chain  = {tag_vld_q, rd_q};
  assign last_chain = {tag_last_q, rd_last_q};
  assign push       = tag_vld_q[READ_LATENCY-1];
  assign pop        = (count_q != '0) & bus.rsp_ready;

  // Reserve a FIFO slot for every read before it is issued, so capture never overflows.
  assign credit_ok  = ((CW+1)'(inflight_q) + (CW+1)'(count_q)) < (CW+1)'(RSP_DEPTH);

  assign inflight_d = inflight_q + CW'(issue) - CW'(push);
  assign count_d    = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    incr_d     = incr_q;
    cs_d       = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    rd_last_d  = 1'b0;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    issue      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cur_addr_d = bus.cmd_addr;
          remain_d   = bus.cmd_len;
          incr_d     = bus.cmd_incr;
          state_d    = bus.cmd_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (bus.wr_valid) begin
          cs_d   = 1'b1;
          wr_d   = 1'b1;
          addr_d = cur_addr_q;
          wdat_d = bus.wr_data;
          if (incr_q) cur_addr_d = cur_addr_q + AW'(1);
          if (remain_q == '0) state_d = S_IDLE;
          else                remain_d = remain_q - LW'(1);
        end
      end
      S_READ: begin
        if (credit_ok) begin
          issue     = 1'b1;
          cs_d      = 1'b1;
          rd_d      = 1'b1;
          addr_d    = cur_addr_q;
          rd_last_d = (remain_q == '0);
          if (incr_q) cur_addr_d = cur_addr_q + AW'(1);
          if (remain_q == '0) state_d = S_DRAIN;
          else                remain_d = remain_q - LW'(1);
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // busy follows the bus by one cycle so it covers the final strobe.
  assign busy_d = (state_d != S_IDLE) | cs_d | (inflight_d != '0) | (count_d != '0);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      incr_q     <= 1'b0;
      cs_q       <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_last_q  <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      busy_q     <= 1'b0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      incr_q     <= incr_d;
      cs_q       <= cs_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rd_last_q  <= rd_last_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      busy_q     <= busy_d;
      tag_vld_q  <= vld_chain[READ_LATENCY-1:0];
      tag_last_q <= last_chain[READ_LATENCY-1:0];
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Payload storage needs no reset: rsp_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {tag_last_q[READ_LATENCY-1], bus.host_d4rd};
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.wr_ready  = (state_q == S_WRITE);
  assign bus.rsp_valid = (count_q != '0);
  assign bus.rsp_data  = mem_q[rptr_q][DW-1:0];
  assign bus.rsp_last  = (count_q != '0) & mem_q[rptr_q][DW];
  assign bus.host_cs   = cs_q;
  assign bus.host_rd   = rd_q;
  assign bus.host_wr   = wr_q;
  assign bus.host_addr = addr_q;
  assign bus.host_d4wt = wdat_q;
  assign busy          = busy_q;

endmodule
